// File: rtl/uart_rx_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_checker_if
// Description : Receive-side handshake bundle of the UART checker. Carries the
//               head-of-FIFO frame (data plus parity/framing status), the
//               valid flag and the consumer's ready.
//               master : the checker (drives data/status/valid, reads ready)
//               slave  : the consumer (reads data/status/valid, drives ready)
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_checker_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] data_o;
    logic                 parity_err_o;
    logic                 frame_err_o;
    logic                 valid_o;
    logic                 ready_i;

    modport master (
        output data_o,
        output parity_err_o,
        output frame_err_o,
        output valid_o,
        input  ready_i
    );

    modport slave (
        input  data_o,
        input  parity_err_o,
        input  frame_err_o,
        input  valid_o,
        output ready_i
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_checker.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_checker
// Description : Configurable UART receiver/checker. Decodes frames of
//               DATA_BITS data bits (LSB first), optional even/odd parity and
//               1 or 2 stop bits from an asynchronous line, and queues each
//               frame with its parity/framing status in a show-ahead FIFO.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               rx_i          - asynchronous serial line, idle high
//               rx_en_i       - enables detection of new start bits
//               clear_i       - pulse, clears overflow_o and count_o
//               bus           - head-of-FIFO frame, valid/ready handshake
//               overflow_o    - sticky, a frame was dropped on a full FIFO
//               count_o       - completed frames, saturating at 0xFFFF
//               busy_o        - receiver is inside a frame
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_checker #(
    parameter int CLKS_PER_BIT = 32,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         rx_i,
    input  wire logic         rx_en_i,
    input  wire logic         clear_i,
    uart_rx_checker_if.master bus,
    output logic              overflow_o,
    output logic [15:0]       count_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    localparam int              c_cw        = $clog2(CLKS_PER_BIT);
    localparam logic [c_cw-1:0] c_half_m1   = c_cw'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cw-1:0] c_bit_m1    = c_cw'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      c_last_data = 4'(DATA_BITS - 1);
    localparam logic [3:0]      c_last_stop = 4'(STOP_BITS - 1);
    localparam logic            c_par_odd   = (PARITY_ODD != 0);
    localparam bit              c_par_en    = (PARITY_EN != 0);
    localparam int              c_aw        = $clog2(FIFO_DEPTH);
    localparam int              c_fw        = c_aw + 1;
    localparam logic [c_fw-1:0] c_depth     = c_fw'(FIFO_DEPTH);
    localparam int              c_ew        = DATA_BITS + 2;

    // ------------------------------------------------------------------
    // Line synchronizer; r_rxs_d remembers the previous synchronized level
    // so IDLE can spot a falling edge.
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rxs;
    logic r_rxs_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
            r_rxs_d   <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rxs     <= r_rx_meta;
            r_rxs_d   <= r_rxs;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_cw-1:0]       r_baud;
    logic [3:0]            r_bit_cnt;
    logic [DATA_BITS-1:0]  r_data;
    logic                  r_perr;
    logic                  r_ferr;

    logic w_fall;
    logic w_tick;
    logic w_push;
    logic w_ferr_final;

    assign w_fall       = r_rxs_d & ~r_rxs;
    assign w_tick       = (r_baud == '0);
    // Status of the frame including the stop sample being taken right now.
    assign w_ferr_final = r_ferr | ~r_rxs;

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_fall && rx_en_i) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                // A line that is high again at mid-start was only a glitch.
                if (w_tick) begin
                    w_state_nxt = r_rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick && (r_bit_cnt == c_last_data)) begin
                    w_state_nxt = c_par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tick && (r_bit_cnt == c_last_stop)) begin
                    w_push      = 1'b1;
                    // A low stop bit may be a break; wait for the line to
                    // recover so the break yields a single frame.
                    w_state_nxt = w_ferr_final ? S_WAIT_HIGH : S_IDLE;
                end
            end
            S_WAIT_HIGH: begin
                if (r_rxs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_data    <= '0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            // The baud counter restarts on every state entry; START only
            // waits half a bit so later samples land mid-bit.
            if ((w_state_nxt != r_state) || w_tick) begin
                r_baud <= (w_state_nxt == S_START) ? c_half_m1 : c_bit_m1;
            end else begin
                r_baud <= r_baud - 1'b1;
            end

            if (w_state_nxt != r_state) begin
                r_bit_cnt <= '0;
            end else if (w_tick && ((r_state == S_DATA) || (r_state == S_STOP))) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            if (w_tick) begin
                unique case (r_state)
                    S_START: begin
                        r_perr <= 1'b0;
                        r_ferr <= 1'b0;
                    end
                    S_DATA: begin
                        // LSB arrives first and ends up at bit 0.
                        r_data <= {r_rxs, r_data[DATA_BITS-1:1]};
                    end
                    S_PARITY: begin
                        r_perr <= (^r_data) ^ r_rxs ^ c_par_odd;
                    end
                    S_STOP: begin
                        r_ferr <= w_ferr_final;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign busy_o = (r_state != S_IDLE);

    // ------------------------------------------------------------------
    // Show-ahead frame FIFO
    // ------------------------------------------------------------------
    logic [c_ew-1:0] r_mem [FIFO_DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_fw-1:0] r_fill;
    logic [c_ew-1:0] w_head;
    logic            w_valid;
    logic            w_full;
    logic            w_pop;
    logic            w_wr;
    logic            w_drop;

    assign w_valid = (r_fill != '0);
    assign w_full  = (r_fill == c_depth);
    assign w_pop   = w_valid & bus.ready_i;
    // A full FIFO still accepts a frame when the head leaves in the same cycle.
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {r_data, r_perr, w_ferr_final};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_wr, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    assign bus.valid_o      = w_valid;
    assign bus.data_o       = w_valid ? w_head[c_ew-1:2] : '0;
    assign bus.parity_err_o = w_valid & w_head[1];
    assign bus.frame_err_o  = w_valid & w_head[0];

    // ------------------------------------------------------------------
    // Statistics: clear beats a completing frame, overflow beats clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            count_o    <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (clear_i) begin
                count_o <= '0;
            end else if (w_push && (count_o != 16'hFFFF)) begin
                count_o <= count_o + 1'b1;
            end

            if (w_drop) begin
                overflow_o <= 1'b1;
            end else if (clear_i) begin
                overflow_o <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_checker
// Description : Self-checking bench. Two checkers: A is 8N1 with a 16-deep
//               FIFO, B is 7 data bits, even parity, 2 stop bits, 4-deep
//               FIFO. Each sent frame is turned into its expected
//               {data, perr, ferr} entry from the line-level bits and queued;
//               a per-cycle compare process checks the FIFO head against it.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_checker;

    localparam int CPB_A = 32;
    localparam int DB_A  = 8;
    localparam int DEP_A = 16;
    localparam int CPB_B = 8;
    localparam int DB_B  = 7;
    localparam int DEP_B = 4;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        rx_a = 1'b1, en_a = 1'b1, clr_a = 1'b0;
    logic        rx_b = 1'b1, en_b = 1'b1, clr_b = 1'b0;
    logic        ovf_a, busy_a, ovf_b, busy_b;
    logic [15:0] cnt_a, cnt_b;

    uart_rx_checker_if #(.DATA_BITS(DB_A)) bus_a ();
    uart_rx_checker_if #(.DATA_BITS(DB_B)) bus_b ();

    uart_rx_checker #(
        .CLKS_PER_BIT(CPB_A), .DATA_BITS(DB_A), .PARITY_EN(0),
        .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(DEP_A)
    ) dut_a (
        .clk(clk), .rst(rst), .rx_i(rx_a), .rx_en_i(en_a), .clear_i(clr_a),
        .bus(bus_a.master), .overflow_o(ovf_a), .count_o(cnt_a), .busy_o(busy_a)
    );

    uart_rx_checker #(
        .CLKS_PER_BIT(CPB_B), .DATA_BITS(DB_B), .PARITY_EN(1),
        .PARITY_ODD(0), .STOP_BITS(2), .FIFO_DEPTH(DEP_B)
    ) dut_b (
        .clk(clk), .rst(rst), .rx_i(rx_b), .rx_en_i(en_b), .clear_i(clr_b),
        .bus(bus_b.master), .overflow_o(ovf_b), .count_o(cnt_b), .busy_o(busy_b)
    );

    // ---------------- model ----------------
    exp_t q_a[$];
    exp_t q_b[$];
    int   m_cnt_a = 0, m_cnt_b = 0;
    logic m_ovf_a = 1'b0, m_ovf_b = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   drain    = 1'b0;
    bit   rdone    = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Expected entry from the bits put on the line: parity error when the
    // number of ones in data plus parity bit is odd (even parity), framing
    // error when any stop bit is low. The FIFO keeps frames while it has room.
    function automatic void model_push(input int w, input logic [8:0] d, input logic pbit,
                                       input logic [1:0] stopv);
        exp_t e;
        if (w == 0) begin
            e.data = {1'b0, d[7:0]};
            e.perr = 1'b0;
            e.ferr = !stopv[0];
            if (m_cnt_a < 65535) m_cnt_a++;
            if (q_a.size() >= DEP_A) m_ovf_a = 1'b1;
            else q_a.push_back(e);
        end else begin
            e.data = {2'b00, d[6:0]};
            e.perr = ((($countones(d[6:0]) + int'(pbit)) % 2) != 0);
            e.ferr = !(stopv[0] && stopv[1]);
            if (m_cnt_b < 65535) m_cnt_b++;
            if (q_b.size() >= DEP_B) m_ovf_b = 1'b1;
            else q_b.push_back(e);
        end
    endfunction

    function automatic void cmp_head(input string tag, input logic [8:0] d, input logic pe,
                                     input logic fe, input exp_t e);
        chk({tag, "_data"}, 32'(d), 32'(e.data));
        chk({tag, "_perr"}, 32'(pe), 32'(e.perr));
        chk({tag, "_ferr"}, 32'(fe), 32'(e.ferr));
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_a.valid_o) begin
                if (q_a.size() == 0) chk("a_head_unexpected", 32'd1, 32'd0);
                else begin
                    cmp_head("a_head", {1'b0, bus_a.data_o}, bus_a.parity_err_o,
                             bus_a.frame_err_o, q_a[0]);
                    if (bus_a.ready_i) void'(q_a.pop_front());
                end
            end else begin
                chk("a_empty_outputs", 32'({bus_a.data_o, bus_a.parity_err_o, bus_a.frame_err_o}), 32'd0);
            end
            if (bus_b.valid_o) begin
                if (q_b.size() == 0) chk("b_head_unexpected", 32'd1, 32'd0);
                else begin
                    cmp_head("b_head", {2'b00, bus_b.data_o}, bus_b.parity_err_o,
                             bus_b.frame_err_o, q_b[0]);
                    if (bus_b.ready_i) void'(q_b.pop_front());
                end
            end else begin
                chk("b_empty_outputs", 32'({bus_b.data_o, bus_b.parity_err_o, bus_b.frame_err_o}), 32'd0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic set_rx(input int w, input logic v);
        if (w == 0) rx_a = v; else rx_b = v;
    endtask

    task automatic set_en(input int w, input logic v);
        if (w == 0) en_a = v; else en_b = v;
    endtask

    task automatic set_ready(input int w, input logic v);
        if (w == 0) bus_a.ready_i = v; else bus_b.ready_i = v;
    endtask

    task automatic pulse_ready(input int w);
        set_ready(w, 1'b1);
        cyc(1);
        set_ready(w, 1'b0);
    endtask

    task automatic send_frame(input int w, input logic [8:0] d, input logic pbit,
                              input logic [1:0] stopv, input bit model, input bit en_drop);
        int cpb, nb, ns;
        cpb = (w == 0) ? CPB_A : CPB_B;
        nb  = (w == 0) ? DB_A : DB_B;
        ns  = (w == 0) ? 1 : 2;
        if (model) model_push(w, d, pbit, stopv);
        set_rx(w, 1'b0);
        cyc(cpb);
        if (en_drop) set_en(w, 1'b0);
        for (int i = 0; i < nb; i++) begin
            set_rx(w, d[i]);
            cyc(cpb);
        end
        if (w == 1) begin
            set_rx(w, pbit);
            cyc(cpb);
        end
        for (int i = 0; i < ns; i++) begin
            set_rx(w, stopv[i]);
            cyc(cpb);
        end
        set_rx(w, 1'b1);
        if (en_drop) set_en(w, 1'b1);
    endtask

    function automatic int qsize(input int w);
        return (w == 0) ? q_a.size() : q_b.size();
    endfunction

    task automatic wait_empty(input int w);
        int k;
        k = 0;
        while ((qsize(w) != 0) && (k < 4000)) begin
            cyc(1);
            k++;
        end
        if (k >= 4000) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_status(input int w, input string tag);
        if (w == 0) begin
            chk({tag, "_count_a"}, 32'(cnt_a), 32'(m_cnt_a));
            chk({tag, "_ovf_a"}, 32'(ovf_a), 32'(m_ovf_a));
            chk({tag, "_busy_a"}, 32'(busy_a), 32'd0);
        end else begin
            chk({tag, "_count_b"}, 32'(cnt_b), 32'(m_cnt_b));
            chk({tag, "_ovf_b"}, 32'(ovf_b), 32'(m_ovf_b));
            chk({tag, "_busy_b"}, 32'(busy_b), 32'd0);
        end
    endtask

    task automatic rand_phase(input int w, input int n);
        rdone = 1'b0;
        drain = 1'b0;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    logic [8:0] d;
                    logic       pb;
                    logic [1:0] sv;
                    bit         ed;
                    if (qsize(w) >= ((w == 0) ? DEP_A - 1 : DEP_B - 1)) begin
                        drain = 1'b1;
                        wait_empty(w);
                        drain = 1'b0;
                    end
                    d  = 9'($urandom);
                    pb = 1'($urandom);
                    sv = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b11;
                    ed = ($urandom_range(0, 3) == 0);
                    send_frame(w, d, pb, sv, 1'b1, ed);
                    cyc((sv != 2'b11) ? 2 * CPB_A : int'($urandom_range(0, 3)));
                    check_status(w, "rand");
                end
                drain = 1'b1;
                wait_empty(w);
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    set_ready(w, drain ? 1'b1 : 1'($urandom_range(0, 1)));
                    cyc(1);
                end
                set_ready(w, 1'b0);
            end
        join
        drain = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        bus_a.ready_i = 1'b0;
        bus_b.ready_i = 1'b0;
        cyc(3);
        chk("reset_valid", 32'(bus_a.valid_o), 32'd0);
        chk("reset_data", 32'(bus_a.data_o), 32'd0);
        chk("reset_count", 32'(cnt_a), 32'd0);
        chk("reset_ovf", 32'(ovf_a), 32'd0);
        chk("reset_busy", 32'({busy_a, busy_b}), 32'd0);
        rst = 1'b0;
        cyc(5);

        // 8N1 decode of 0x65
        send_frame(0, 9'h065, 1'b0, 2'b11, 1'b1, 1'b0);
        cyc(2);
        chk("8n1_valid", 32'(bus_a.valid_o), 32'd1);
        chk("8n1_data", 32'(bus_a.data_o), 32'h65);
        chk("8n1_flags", 32'({bus_a.parity_err_o, bus_a.frame_err_o}), 32'd0);
        chk("8n1_count", 32'(cnt_a), 32'd1);
        pulse_ready(0);
        chk("8n1_popped", 32'(bus_a.valid_o), 32'd0);

        // Glitch of 10 cycles is rejected
        rx_a = 1'b0;
        cyc(5);
        chk("glitch_busy", 32'(busy_a), 32'd1);
        cyc(5);
        rx_a = 1'b1;
        cyc(CPB_A);
        chk("glitch_idle", 32'(busy_a), 32'd0);
        chk("glitch_count", 32'(cnt_a), 32'd1);
        chk("glitch_valid", 32'(bus_a.valid_o), 32'd0);

        // Disabled receiver ignores a frame
        en_a = 1'b0;
        send_frame(0, 9'h0F0, 1'b0, 2'b11, 1'b0, 1'b0);
        cyc(4);
        en_a = 1'b1;
        chk("rxen_off_count", 32'(cnt_a), 32'd1);
        chk("rxen_off_valid", 32'(bus_a.valid_o), 32'd0);

        // Dropping rx_en mid-frame does not abort it
        send_frame(0, 9'h0C3, 1'b0, 2'b11, 1'b1, 1'b1);
        cyc(2);
        chk("rxen_drop_count", 32'(cnt_a), 32'd2);
        chk("rxen_drop_data", 32'(bus_a.data_o), 32'hC3);
        pulse_ready(0);

        // Break: 20 bit times low gives exactly one framing-error frame
        model_push(0, 9'h000, 1'b0, 2'b00);
        rx_a = 1'b0;
        cyc(20 * CPB_A);
        chk("break_busy", 32'(busy_a), 32'd1);
        chk("break_count", 32'(cnt_a), 32'd3);
        chk("break_entry", 32'({bus_a.valid_o, bus_a.data_o, bus_a.frame_err_o}), 32'h201);
        rx_a = 1'b1;
        cyc(4);
        chk("break_release", 32'(busy_a), 32'd0);
        send_frame(0, 9'h05A, 1'b0, 2'b11, 1'b1, 1'b0);
        cyc(2);
        chk("break_after_count", 32'(cnt_a), 32'd4);
        pulse_ready(0);
        chk("break_second", 32'({bus_a.data_o, bus_a.parity_err_o, bus_a.frame_err_o}), 32'(10'h168));
        pulse_ready(0);
        check_status(0, "break");

        // Overflow: 17 frames into a 16-deep FIFO
        clr_a = 1'b1;
        cyc(1);
        clr_a = 1'b0;
        m_cnt_a = 0;
        m_ovf_a = 1'b0;
        chk("clear_count", 32'(cnt_a), 32'd0);
        for (int i = 0; i < 17; i++) begin
            send_frame(0, 9'(i), 1'b0, 2'b11, 1'b1, 1'b0);
        end
        cyc(2);
        chk("ovf_count", 32'(cnt_a), 32'd17);
        chk("ovf_flag", 32'(ovf_a), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk("ovf_drain_order", 32'(bus_a.data_o), 32'(i));
            pulse_ready(0);
        end
        chk("ovf_drained", 32'(bus_a.valid_o), 32'd0);
        clr_a = 1'b1;
        cyc(1);
        clr_a = 1'b0;
        m_cnt_a = 0;
        m_ovf_a = 1'b0;
        chk("ovf_clear", 32'({ovf_a, cnt_a}), 32'd0);

        // Parity on B: 0x03 with parity bit 1 is wrong, with 0 is right
        send_frame(1, 9'h003, 1'b1, 2'b11, 1'b1, 1'b0);
        cyc(2);
        chk("par_bad", 32'({bus_b.valid_o, bus_b.data_o, bus_b.parity_err_o, bus_b.frame_err_o}), 32'h20E);
        pulse_ready(1);
        send_frame(1, 9'h003, 1'b0, 2'b11, 1'b1, 1'b0);
        cyc(2);
        chk("par_good", 32'({bus_b.valid_o, bus_b.data_o, bus_b.parity_err_o, bus_b.frame_err_o}), 32'h20C);
        pulse_ready(1);
        send_frame(1, 9'h055, 1'b0, 2'b01, 1'b1, 1'b0);
        cyc(2 * CPB_B);
        chk("stop2_ferr", 32'(bus_b.frame_err_o), 32'd1);
        pulse_ready(1);
        check_status(1, "b_directed");

        // Randomized traffic
        rand_phase(0, 25);
        chk("a_rand_leftover", 32'(q_a.size()), 32'd0);
        rand_phase(1, 60);
        chk("b_rand_leftover", 32'(q_b.size()), 32'd0);

        // Reset mid-frame with a non-empty FIFO
        send_frame(0, 9'h011, 1'b0, 2'b11, 1'b1, 1'b0);
        cyc(2);
        chk("prerst_valid", 32'(bus_a.valid_o), 32'd1);
        rx_a = 1'b0;
        cyc(CPB_A + CPB_A / 2 + 2 * CPB_A);
        chk("prerst_busy", 32'(busy_a), 32'd1);
        rst  = 1'b1;
        rx_a = 1'b1;
        cyc(1);
        chk("rst_outputs", 32'({bus_a.valid_o, bus_a.data_o, bus_a.parity_err_o,
                               bus_a.frame_err_o, ovf_a, busy_a}), 32'd0);
        chk("rst_count", 32'(cnt_a), 32'd0);
        rst = 1'b0;
        q_a.delete();
        q_b.delete();
        m_cnt_a = 0;
        m_cnt_b = 0;
        m_ovf_a = 1'b0;
        m_ovf_b = 1'b0;
        cyc(5);
        send_frame(0, 9'h0A5, 1'b0, 2'b11, 1'b1, 1'b0);
        cyc(2);
        chk("post_rst_data", 32'(bus_a.data_o), 32'hA5);
        chk("post_rst_count", 32'(cnt_a), 32'd1);
        pulse_ready(0);
        check_status(0, "post_rst");

        cyc(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_checker.md
# uart_rx_checker

Parametrised, synthesizable UART receive checker for the PULPino bench and FPGA harness. It samples the chip's `uart_tx` line and decodes frames with a configurable format: 5–9 data bits, optional even/odd parity, and 1 or 2 stop bits. Each frame is buffered together with its parity and framing status in a FIFO and presented to the consumer through a valid/ready handshake. It replaces the fixed 8N1 behavioural UART model with a block that can also run on silicon-validation boards.

## Interface
Parameters:
- `CLKS_PER_BIT`, 32, clock cycles per bit (25 MHz / 781250 baud); must be even and ≥ 4
- `DATA_BITS`, 8, data bits per frame, 5..9
- `PARITY_EN`, 0, 1 = parity bit present
- `PARITY_ODD`, 0, 1 = odd parity, 0 = even; ignored when `PARITY_EN` = 0
- `STOP_BITS`, 1, 1 or 2
- `FIFO_DEPTH`, 16, power of two, ≥ 2

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset
- `rx_i`  in  1  asynchronous serial line; idle level is high
- `rx_en_i`  in  1  enables detection of new start bits
- `clear_i`  in  1  one-cycle pulse; clears `overflow_o` and `count_o`
- `data_o`  out  DATA_BITS  head-of-FIFO data; 0 when FIFO empty
- `parity_err_o`  out  1  head-of-FIFO parity error; 0 when empty
- `frame_err_o`  out  1  head-of-FIFO stop-bit error; 0 when empty
- `valid_o`  out  1  FIFO not empty
- `ready_i`  in  1  pops the head when `valid_o && ready_i`
- `overflow_o`  out  1  sticky; set when a frame is dropped because the FIFO is full
- `count_o`  out  16  number of completed frames, saturating at 0xFFFF
- `busy_o`  out  1  FSM is not in IDLE

## Operation
- **Input synchronizer:** two flops on `rx_i`, both reset to 1. All decoding uses the second flop, `rxs`. A falling edge is `rxs == 0` while the previous `rxs == 1`.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- **Baud counter:** reloaded on every state entry.
- **IDLE:** on a falling edge with `rx_en_i == 1`, go to START. Otherwise stay in IDLE.
- **START:** wait `CLKS_PER_BIT/2` cycles, then sample the line.
  - If `rxs == 1`, treat it as a glitch: return to IDLE, no frame, `count_o` unchanged.
  - If `rxs == 0`, go to DATA.
- **DATA:** take `DATA_BITS` samples spaced `CLKS_PER_BIT` apart, LSB first. Then go to PARITY if `PARITY_EN`, otherwise to STOP.
- **PARITY:** take one sample.
  - `perr = ^data ^ pbit ^ PARITY_ODD`. Even parity expects XOR(data, pbit) = 0.
  - `perr` is forced to 0 when `PARITY_EN` = 0.
- **STOP:** sample `STOP_BITS` bits. `ferr` = 1 if any stop sample is 0.
- **Frame completion:** on the last stop sample, push `{data, perr, ferr}` to the FIFO and increment `count_o`.
  - If `ferr == 0`, go to IDLE.
  - If `ferr == 1`, go to WAIT_HIGH.
- **WAIT_HIGH:** stay until `rxs == 1`, then go to IDLE. This keeps a break condition from producing repeated frames.
- **`rx_en_i`:** deasserting it mid-frame does not abort; the current frame completes normally.
- **FIFO:** show-ahead (head entry visible on the outputs).
  - Pop when `valid_o && ready_i`.
  - Push while full without a same-cycle pop: the new frame is dropped, `overflow_o` is set, and `count_o` still increments.
  - Push and pop in the same cycle while full: both take effect, no overflow.
- **`clear_i`:** zeroes `count_o` and `overflow_o`. It does not flush the FIFO or affect the FSM.
  - If `clear_i` coincides with a frame completion, the clear wins (`count_o` = 0).
  - If `clear_i` coincides with an overflow, the overflow wins (`overflow_o` = 1).
- **`rst`:** from any state, the next cycle shows IDLE, an empty FIFO, and every output at its reset value. A frame in progress is discarded.

## Timing
- **Reset values:** `data_o` 0, `parity_err_o` 0, `frame_err_o` 0, `valid_o` 0, `overflow_o` 0, `count_o` 0, `busy_o` 0.
- **Synchronizer latency:** 2 cycles from `rx_i` to `rxs`.
- **Sample points:** let cycle E be the cycle in which the falling edge of `rxs` is seen.
  - Start sample at E + `CLKS_PER_BIT/2`.
  - Bit k (k = 0 for the first data bit) at E + `CLKS_PER_BIT/2` + (k+1)·`CLKS_PER_BIT`.
- **Push latency:** the push happens on the clock edge ending the last stop sample cycle S. In cycle S+1, `valid_o` = 1 and `count_o` shows the new value.
- **`busy_o`:** 1 from E+1. It is 0 again in cycle S+1, or in the cycle after `rxs` returns high when leaving WAIT_HIGH.
- **Back-to-back frames:** a start bit beginning right after the stop bit is accepted. IDLE is re-entered at mid-stop, before the next falling edge.
- **Pop latency:** the pop takes effect on the handshake edge; the next entry, or empty, is visible in the following cycle.

## Test plan
- **8N1 decode:** 8N1, `CLKS_PER_BIT` = 32, send 0x65, `ready_i` = 0 → `valid_o` = 1, `data_o` = 0x65, both error flags 0, `count_o` = 1; pulse `ready_i` → `valid_o` = 0 next cycle.
- **Glitch rejection:** hold `rx_i` low for 10 cycles, then high → no frame, `busy_o` returns to 0, `count_o` = 0.
- **Parity error:** `PARITY_EN` = 1, even parity, send 0x03 with parity bit 1 → `data_o` = 0x03, `parity_err_o` = 1. Repeat with parity bit 0 → `parity_err_o` = 0.
- **Break handling:** hold `rx_i` low for 20 bit times → exactly one frame with `data_o` = 0x00 and `frame_err_o` = 1. Release `rx_i`, then send 0x5A → second frame 0x5A with no errors.
- **Overflow:** `FIFO_DEPTH` = 16, `ready_i` = 0, send 17 frames 0x00..0x10 → `count_o` = 17, `overflow_o` = 1. Draining yields 0x00..0x0F in order. `clear_i` → `count_o` = 0, `overflow_o` = 0.
- **Reset mid-frame:** assert `rst` for one cycle during DATA → all outputs at reset values next cycle. A following 0xA5 frame decodes correctly with `count_o` = 1.
